// File: rtl/cmos_rc_pkg.sv
// Shared types, default parameters and the saturating integrator step
// for the RC-input Schmitt conditioning block.
package cmos_rc_pkg;

  typedef enum logic {RC_LOW, RC_HIGH} rc_state_t;

  localparam int unsigned DEF_CHANNELS       = 6;
  localparam int unsigned DEF_CNT_W          = 8;
  localparam int unsigned DEF_CHARGE_STEP    = 16;
  localparam int unsigned DEF_DISCHARGE_STEP = 16;
  localparam int unsigned DEF_VTH_HI         = 192;
  localparam int unsigned DEF_VTH_LO         = 64;

  // Charge (dir=1) or discharge (dir=0) by step, clamped to [0, acc_max].
  function automatic int unsigned sat_step(input int unsigned acc,
                                           input int unsigned step,
                                           input logic        dir,
                                           input int unsigned acc_max);
    int unsigned sum;
    if (dir) begin
      sum = acc + step;
      return (sum > acc_max) ? acc_max : sum;
    end
    return (acc > step) ? acc - step : 0;
  endfunction

endpackage

// File: rtl/rc_schmitt_channel.sv
// One RC integrator channel: saturating accumulator, two-state Schmitt
// hysteresis and registered rise/fall strobes.
module rc_schmitt_channel
  import cmos_rc_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned CHARGE_STEP    = DEF_CHARGE_STEP,
  parameter int unsigned DISCHARGE_STEP = DEF_DISCHARGE_STEP,
  parameter int unsigned VTH_HI         = DEF_VTH_HI,
  parameter int unsigned VTH_LO         = DEF_VTH_LO,
  parameter bit          INIT_HIGH      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             raw,
  output logic             clean,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] acc
);

  localparam int unsigned      ACC_MAX  = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] TH_HI    = CNT_W'(VTH_HI);
  localparam logic [CNT_W-1:0] TH_LO    = CNT_W'(VTH_LO);
  localparam logic [CNT_W-1:0] ACC_INIT = INIT_HIGH ? '1 : '0;
  localparam rc_state_t        ST_INIT  = INIT_HIGH ? RC_HIGH : RC_LOW;

  rc_state_t        state, state_next;
  logic [CNT_W-1:0] acc_next;
  logic             rise_next, fall_next;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    acc_next   = acc;
    state_next = state;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (cen) begin
      acc_next = CNT_W'(sat_step(32'(acc), raw ? CHARGE_STEP : DISCHARGE_STEP,
                                 raw, ACC_MAX));
      // Thresholds look at acc_next so the level moves on the crossing edge.
      unique case (state)
        RC_LOW: if (acc_next >= TH_HI) begin
          state_next = RC_HIGH;
          rise_next  = 1'b1;
        end
        RC_HIGH: if (acc_next <= TH_LO) begin
          state_next = RC_LOW;
          fall_next  = 1'b1;
        end
        default: state_next = RC_LOW;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= ACC_INIT;
      state <= ST_INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      acc   <= acc_next;
      state <= state_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  assign clean = (state == RC_HIGH);

endmodule

// File: rtl/cmos_4584_rc_input.sv
// Bank of independent RC/Schmitt input conditioners feeding the hex
// inverter stage; channel 0's accumulator is exposed for debug.
module cmos_4584_rc_input
  import cmos_rc_pkg::*;
#(
  parameter int unsigned CHANNELS       = DEF_CHANNELS,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned CHARGE_STEP    = DEF_CHARGE_STEP,
  parameter int unsigned DISCHARGE_STEP = DEF_DISCHARGE_STEP,
  parameter int unsigned VTH_HI         = DEF_VTH_HI,
  parameter int unsigned VTH_LO         = DEF_VTH_LO,
  parameter bit          INIT_HIGH      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cen,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CNT_W-1:0]    acc0_dbg
);

  localparam int unsigned ACC_MAX = (1 << CNT_W) - 1;

  if (VTH_LO >= VTH_HI) begin : g_err_thresh_order
    $error("cmos_4584_rc_input: VTH_LO must be below VTH_HI");
  end
  if (VTH_HI > ACC_MAX) begin : g_err_thresh_range
    $error("cmos_4584_rc_input: VTH_HI exceeds accumulator full scale");
  end
  if (CHARGE_STEP == 0 || CHARGE_STEP > ACC_MAX ||
      DISCHARGE_STEP == 0 || DISCHARGE_STEP > ACC_MAX) begin : g_err_step
    $error("cmos_4584_rc_input: steps must be in 1..ACC_MAX");
  end

  logic [CHANNELS-1:0][CNT_W-1:0] acc_all;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    rc_schmitt_channel #(
      .CNT_W          (CNT_W),
      .CHARGE_STEP    (CHARGE_STEP),
      .DISCHARGE_STEP (DISCHARGE_STEP),
      .VTH_HI         (VTH_HI),
      .VTH_LO         (VTH_LO),
      .INIT_HIGH      (INIT_HIGH)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .cen   (cen),
      .raw   (raw_in[n]),
      .clean (clean_out[n]),
      .rise  (rise[n]),
      .fall  (fall[n]),
      .acc   (acc_all[n])
    );
  end

  assign acc0_dbg = acc_all[0];

  // Only channel 0's accumulator leaves the block; the rest are internal.
  logic unused_acc;
  assign unused_acc = ^acc_all;

endmodule
